// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one downstream memory command port between an instruction
// read port and a data read/write port. Define ARB_TIMEOUT_EN to enable the WAIT watchdog.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES     = 1024,
  parameter bit          RESET_LAST_GRANT_D = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cmd_start,
  output logic        i_cmd_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_rdata_valid,
  input  logic        d_cmd_start,
  input  logic        d_cmd_write,
  output logic        d_cmd_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_rdata_valid,
  output logic        mem_cmd_start,
  output logic        mem_cmd_write,
  input  logic        mem_cmd_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_valid,
  output logic        arb_timeout
);

  // Handshake rule: a transfer happens on any cycle where start and ready are both 1;
  // upstream ready is combinational from the other port's start, only in IDLE.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic        r_last_grant_d;
  logic        r_owner_d;
  logic        r_mem_cmd_start;
  logic        r_mem_cmd_write;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_i_rdata;
  logic [31:0] r_d_rdata;
  logic        r_i_rdata_valid;
  logic        r_d_rdata_valid;
  logic        r_arb_timeout;

  logic        w_idle;
  logic        w_i_ready;
  logic        w_d_ready;
  logic        w_i_acc;
  logic        w_d_acc;
  logic        w_timeout_hit;
  logic        w_resp_done;
  logic [31:0] w_resp_data;

  assign w_idle    = (r_state == S_IDLE) && !rst;
  assign w_i_ready = w_idle && !(d_cmd_start && !r_last_grant_d);
  assign w_d_ready = w_idle && !(i_cmd_start && r_last_grant_d);
  assign w_i_acc   = i_cmd_start && w_i_ready;
  assign w_d_acc   = d_cmd_start && w_d_ready;

`ifdef ARB_TIMEOUT_EN
  logic [31:0] r_wait_cnt;

  // Counts completed WAIT cycles; cleared as the read leaves ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= 32'd0;
    end else if (r_state == S_ISSUE) begin
      r_wait_cnt <= 32'd0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 32'd1;
    end
  end

  assign w_timeout_hit = (r_wait_cnt + 32'd1) >= 32'(TIMEOUT_CYCLES);
`else
  assign w_timeout_hit = 1'b0;
`endif

  assign w_resp_done = mem_rdata_valid || w_timeout_hit;
  assign w_resp_data = mem_rdata_valid ? mem_rdata : 32'hFFFF_FFFF;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_last_grant_d  <= RESET_LAST_GRANT_D;
      r_owner_d       <= 1'b0;
      r_mem_cmd_start <= 1'b0;
      r_mem_cmd_write <= 1'b0;
      r_mem_addr      <= 32'd0;
      r_mem_wdata     <= 32'd0;
      r_i_rdata       <= 32'd0;
      r_d_rdata       <= 32'd0;
      r_i_rdata_valid <= 1'b0;
      r_d_rdata_valid <= 1'b0;
      r_arb_timeout   <= 1'b0;
    end else begin
      r_i_rdata_valid <= 1'b0;
      r_d_rdata_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_i_acc) begin
            r_mem_addr      <= i_addr;
            r_mem_cmd_write <= 1'b0;
            r_owner_d       <= 1'b0;
            r_last_grant_d  <= 1'b0;
            r_mem_cmd_start <= 1'b1;
            r_state         <= S_ISSUE;
          end else if (w_d_acc) begin
            r_mem_addr      <= d_addr;
            r_mem_cmd_write <= d_cmd_write;
            r_mem_wdata     <= d_wdata;
            r_owner_d       <= 1'b1;
            r_last_grant_d  <= 1'b1;
            r_mem_cmd_start <= 1'b1;
            r_state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_cmd_ready) begin
            r_mem_cmd_start <= 1'b0;
            r_state         <= r_mem_cmd_write ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          // mem_addr stays put here: downstream response muxing decodes it.
          if (w_resp_done) begin
            if (r_owner_d) begin
              r_d_rdata       <= w_resp_data;
              r_d_rdata_valid <= 1'b1;
            end else begin
              r_i_rdata       <= w_resp_data;
              r_i_rdata_valid <= 1'b1;
            end
            if (!mem_rdata_valid) begin
              r_arb_timeout <= 1'b1;
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign i_cmd_ready   = w_i_ready;
  assign d_cmd_ready   = w_d_ready;
  assign i_rdata       = r_i_rdata;
  assign i_rdata_valid = r_i_rdata_valid;
  assign d_rdata       = r_d_rdata;
  assign d_rdata_valid = r_d_rdata_valid;
  assign mem_cmd_start = r_mem_cmd_start;
  assign mem_cmd_write = r_mem_cmd_write;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign arb_timeout   = r_arb_timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: requester tasks push expectations, a downstream
// responder and an rdata monitor pop and compare them.
module tb_mem_port_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_cmd_start;
  logic         i_cmd_ready;
  logic [W-1:0] i_addr;
  logic [W-1:0] i_rdata;
  logic         i_rdata_valid;
  logic         d_cmd_start;
  logic         d_cmd_write;
  logic         d_cmd_ready;
  logic [W-1:0] d_addr;
  logic [W-1:0] d_wdata;
  logic [W-1:0] d_rdata;
  logic         d_rdata_valid;
  logic         mem_cmd_start;
  logic         mem_cmd_write;
  logic         mem_cmd_ready;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;
  logic         mem_rdata_valid;
  logic         arb_timeout;

  mem_port_arbiter #(
    .TIMEOUT_CYCLES    (8),
    .RESET_LAST_GRANT_D(1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_cmd_start    (i_cmd_start),
    .i_cmd_ready    (i_cmd_ready),
    .i_addr         (i_addr),
    .i_rdata        (i_rdata),
    .i_rdata_valid  (i_rdata_valid),
    .d_cmd_start    (d_cmd_start),
    .d_cmd_write    (d_cmd_write),
    .d_cmd_ready    (d_cmd_ready),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_rdata        (d_rdata),
    .d_rdata_valid  (d_rdata_valid),
    .mem_cmd_start  (mem_cmd_start),
    .mem_cmd_write  (mem_cmd_write),
    .mem_cmd_ready  (mem_cmd_ready),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_rdata_valid(mem_rdata_valid),
    .arb_timeout    (arb_timeout)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] i_exp_q[$];
  logic [W-1:0] d_exp_q[$];
  logic [W-1:0] cmd_addr_q[$];
  logic [W-1:0] cmd_wr_q[$];
  logic [W-1:0] cmd_wdata_q[$];
  int           grant_log[$];
  int           ready_delay = 0;
  int           resp_lat    = 2;
  bit           no_resp     = 1'b0;
  bit           hold_en     = 1'b1;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mem_model(input logic [W-1:0] a);
    if (a == 32'h0000_0100) return 32'h0000_0013;
    return a ^ 32'hA5A5_0F0F;
  endfunction

  // Downstream memory: ready after ready_delay cycles, read data resp_lat cycles after accept
  initial begin : responder
    logic [W-1:0] rec_addr;
    logic [W-1:0] wr_exp;
    logic [W-1:0] wd_exp;
    int wcnt;
    int lcnt;
    bit pending;
    bit held;
    wcnt = 0; lcnt = 0; pending = 1'b0; held = 1'b0; rec_addr = '0;
    mem_cmd_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_cmd_ready   = 1'b0;
      mem_rdata_valid = 1'b0;
      if (pending) begin
        if (held) check("mem_addr_hold", mem_addr, rec_addr);
        lcnt--;
        if (lcnt <= 0) begin
          mem_rdata_valid = 1'b1;
          mem_rdata       = mem_model(rec_addr);
          pending         = 1'b0;
        end
      end else if (mem_cmd_start) begin
        if (wcnt >= ready_delay) begin
          mem_cmd_ready = 1'b1;
          wcnt = 0;
          if (cmd_addr_q.size() > 0) begin
            wr_exp = cmd_wr_q.pop_front();
            wd_exp = cmd_wdata_q.pop_front();
            check("mem_addr", mem_addr, cmd_addr_q.pop_front());
            check("mem_cmd_write", 32'(mem_cmd_write), wr_exp);
            if (wr_exp[0]) check("mem_wdata", mem_wdata, wd_exp);
          end else begin
            check("mem_cmd_unexpected", 32'(mem_cmd_start), 32'd0);
          end
          if (!mem_cmd_write && !no_resp) begin
            pending  = 1'b1;
            held     = hold_en;
            lcnt     = resp_lat;
            rec_addr = mem_addr;
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Response monitor: every rdata_valid pulse must match a queued expectation
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (i_rdata_valid) begin
        if (i_exp_q.size() > 0) check("i_rdata", i_rdata, i_exp_q.pop_front());
        else check("i_rdata_valid_unexpected", 32'(i_rdata_valid), 32'd0);
      end
      if (d_rdata_valid) begin
        if (d_exp_q.size() > 0) check("d_rdata", d_rdata, d_exp_q.pop_front());
        else check("d_rdata_valid_unexpected", 32'(d_rdata_valid), 32'd0);
      end
    end
  end

  // Driver tasks: called aligned to a negedge, return one negedge after acceptance
  task automatic i_req(input logic [W-1:0] addr, input logic [W-1:0] exp_rd);
    int n;
    n = 0;
    i_cmd_start = 1'b1;
    i_addr      = addr;
    #1;
    while (!i_cmd_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    check("i_accept", 32'(i_cmd_ready), 32'd1);
    if (i_cmd_ready) begin
      i_exp_q.push_back(exp_rd);
      cmd_addr_q.push_back(addr);
      cmd_wr_q.push_back(32'd0);
      cmd_wdata_q.push_back(32'd0);
      grant_log.push_back(0);
    end
    @(negedge clk);
    i_cmd_start = 1'b0;
  endtask

  task automatic d_req(input logic wr, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                       input logic [W-1:0] exp_rd);
    int n;
    n = 0;
    d_cmd_start = 1'b1;
    d_cmd_write = wr;
    d_addr      = addr;
    d_wdata     = wdata;
    #1;
    while (!d_cmd_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    check("d_accept", 32'(d_cmd_ready), 32'd1);
    if (d_cmd_ready) begin
      if (!wr) d_exp_q.push_back(exp_rd);
      cmd_addr_q.push_back(addr);
      cmd_wr_q.push_back(32'(wr));
      cmd_wdata_q.push_back(wdata);
      grant_log.push_back(1);
    end
    @(negedge clk);
    d_cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((i_exp_q.size() + d_exp_q.size() + cmd_addr_q.size()) != 0 && n < 500) begin
      @(negedge clk); n++;
    end
    check(tag, 32'(n < 500), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin : stimulus
    int cnt;
    rst = 1'b1;
    i_cmd_start = 1'b0; i_addr = '0;
    d_cmd_start = 1'b0; d_cmd_write = 1'b0; d_addr = '0; d_wdata = '0;

    // Reset values, with both starts high to show ready stays low in reset
    repeat (2) @(negedge clk);
    i_cmd_start = 1'b1; d_cmd_start = 1'b1;
    #1;
    check("rst_i_cmd_ready", 32'(i_cmd_ready), 32'd0);
    check("rst_d_cmd_ready", 32'(d_cmd_ready), 32'd0);
    check("rst_mem_cmd_start", 32'(mem_cmd_start), 32'd0);
    check("rst_mem_cmd_write", 32'(mem_cmd_write), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_i_rdata_valid", 32'(i_rdata_valid), 32'd0);
    check("rst_d_rdata_valid", 32'(d_rdata_valid), 32'd0);
    check("rst_arb_timeout", 32'(arb_timeout), 32'd0);
    i_cmd_start = 1'b0; d_cmd_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Tie in the first IDLE: instruction wins, then data
    grant_log.delete();
    fork
      i_req(32'h0000_0200, mem_model(32'h0000_0200));
      d_req(1'b0, 32'h8000_0000, 32'd0, mem_model(32'h8000_0000));
    join
    wait_done("t2_done");
    check("t2_grants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      check("t2_grant0", 32'(grant_log[0]), 32'd0);
      check("t2_grant1", 32'(grant_log[1]), 32'd1);
    end

    // Single instruction read, downstream ready at once, data two cycles later
    ready_delay = 0; resp_lat = 2;
    i_req(32'h0000_0100, 32'h0000_0013);
    wait_done("t1_done");
    check("t1_i_rdata_hold", i_rdata, 32'h0000_0013);
    check("t1_d_rdata_untouched", d_rdata, mem_model(32'h8000_0000));

    // Data write with downstream ready held low for three cycles
    ready_delay = 3;
    d_req(1'b1, 32'h1000_0004, 32'hCAFE_BABE, 32'd0);
    cnt = 0;
    for (int k = 0; k < 20 && mem_cmd_start; k++) begin
      check("t3_wdata_stable", mem_wdata, 32'hCAFE_BABE);
      check("t3_addr_stable", mem_addr, 32'h1000_0004);
      cnt++;
      @(negedge clk);
    end
    check("t3_start_cycles", 32'(cnt), 32'd4);
    #1;
    check("t3_idle_after_accept", 32'(i_cmd_ready), 32'd1);
    @(negedge clk);
    ready_delay = 0;
    wait_done("t3_done");

    // Both ports hold start continuously: strict alternation
    grant_log.delete();
    resp_lat = 1 + $urandom_range(0, 2);
    fork
      for (int k = 0; k < 3; k++) i_req(32'h0000_2000 + 32'(k * 4), mem_model(32'h0000_2000 + 32'(k * 4)));
      for (int k = 0; k < 3; k++) d_req(1'b0, 32'h0000_3000 + 32'(k * 4), 32'd0, mem_model(32'h0000_3000 + 32'(k * 4)));
    join
    wait_done("t4_done");
    check("t4_grants", 32'(grant_log.size()), 32'd6);
    for (int k = 0; k < grant_log.size(); k++) check("t4_alternate", 32'(grant_log[k]), 32'(k % 2));

    // Reset while waiting for read data; the late response must be ignored
    resp_lat = 4; hold_en = 1'b0;
    i_req(32'h0000_0300, mem_model(32'h0000_0300));
    @(negedge clk);
    rst = 1'b1; i_cmd_start = 1'b1; d_cmd_start = 1'b1;
    #1;
    check("t5_rst_i_ready", 32'(i_cmd_ready), 32'd0);
    check("t5_rst_d_ready", 32'(d_cmd_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0; i_cmd_start = 1'b0; d_cmd_start = 1'b0;
    i_exp_q.delete();
    repeat (8) @(negedge clk);
    #1;
    check("t5_idle_i_ready", 32'(i_cmd_ready), 32'd1);
    check("t5_idle_d_ready", 32'(d_cmd_ready), 32'd1);
    check("t5_i_rdata_cleared", i_rdata, 32'd0);
    check("t5_mem_cmd_start", 32'(mem_cmd_start), 32'd0);
    @(negedge clk);
    hold_en = 1'b1; resp_lat = 2;

`ifdef ARB_TIMEOUT_EN
    // No downstream response: watchdog returns all-ones and sets the sticky flag
    no_resp = 1'b1;
    d_req(1'b0, 32'h0000_0400, 32'd0, 32'hFFFF_FFFF);
    wait_done("t6_done");
    check("t6_arb_timeout", 32'(arb_timeout), 32'd1);
    check("t6_d_rdata", d_rdata, 32'hFFFF_FFFF);
    no_resp = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_timeout_cleared", 32'(arb_timeout), 32'd0);
    @(negedge clk);
`else
    check("arb_timeout_tied", 32'(arb_timeout), 32'd0);
`endif

    check("end_i_q_empty", 32'(i_exp_q.size()), 32'd0);
    check("end_d_q_empty", 32'(d_exp_q.size()), 32'd0);
    check("end_cmd_q_empty", 32'(cmd_addr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter in front of the memory map controller: instruction fetch port (read-only) and data port (read/write) share one downstream cmd_start/cmd_ready/rdata_valid interface.
- Registers each granted command and holds addr/write/wdata stable from issue until completion; the downstream ready/rdata/rdata_valid muxing is address-decoded, so a moving address corrupts the response.
- Round-robin grant when both requesters start in the same cycle; one outstanding transaction at a time.

Parameters:
- TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit; used only with ARB_TIMEOUT_EN.
- RESET_LAST_GRANT_D, 1, initial round-robin history; 1 = data was last granted, so instruction wins the first tie.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_cmd_start  in  1  instruction read request
- i_cmd_ready  out  1  instruction request accepted this cycle if i_cmd_start=1
- i_addr  in  32  instruction address
- i_rdata  out  32  instruction read data
- i_rdata_valid  out  1  one-cycle pulse, i_rdata valid
- d_cmd_start  in  1  data request
- d_cmd_write  in  1  1 = write, 0 = read
- d_cmd_ready  out  1  data request accepted this cycle if d_cmd_start=1
- d_addr  in  32  data address
- d_wdata  in  32  write data
- d_rdata  out  32  data read data
- d_rdata_valid  out  1  one-cycle pulse, d_rdata valid
- mem_cmd_start  out  1  downstream command start
- mem_cmd_write  out  1  downstream write flag
- mem_cmd_ready  in  1  downstream ready
- mem_addr  out  32  downstream address (registered)
- mem_wdata  out  32  downstream write data (registered)
- mem_rdata  in  32  downstream read data
- mem_rdata_valid  in  1  downstream read data valid
- arb_timeout  out  1  sticky watchdog flag

Behaviour:
- Clocking/reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Handshakes: a request is accepted on a cycle with x_cmd_start && x_cmd_ready. A downstream command is accepted on a cycle with mem_cmd_start && mem_cmd_ready.
- Reset values: state=IDLE; all cmd_ready, mem_cmd_start, mem_cmd_write, *_rdata_valid and arb_timeout = 0; mem_addr, mem_wdata, i_rdata, d_rdata = 0; last_grant = RESET_LAST_GRANT_D; owner = I.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, ready outputs:
  - i_cmd_ready = !(d_cmd_start && last_grant==I)
  - d_cmd_ready = !(i_cmd_start && last_grant==D)
  - Both are 0 in every other state and during rst.
  - Combinational start→ready path is intentional.
- IDLE, on acceptance: latch addr, write flag (instruction port forces 0) and wdata into mem_* registers; set owner and last_grant to the winner; go to ISSUE.
- ISSUE: mem_cmd_start=1; mem_addr, mem_cmd_write and mem_wdata are held. On mem_cmd_ready=1: go to IDLE if write, WAIT if read. mem_cmd_start deasserts the cycle after acceptance.
- WAIT: mem_addr held. On mem_rdata_valid=1: register mem_rdata into the owner's x_rdata and go to RESP.
- RESP: owner's x_rdata_valid=1 for exactly this cycle, then IDLE.
- Latencies:
  - Read, request accept → x_rdata_valid: 1 (ISSUE) + downstream latency + 1 cycle.
  - Write completes on downstream acceptance; there is no response pulse to the requester.
- Data hold: x_rdata holds its last value after the pulse. The non-owner's rdata and rdata_valid are untouched.
- Fairness: the same requester is never granted twice in a row while the other holds start=1 in IDLE.
- Boundary conditions:
  - mem_rdata_valid outside WAIT is ignored.
  - mem_cmd_ready outside ISSUE is ignored.
  - rst mid-transaction forces IDLE immediately; the outstanding read is dropped and no rdata_valid pulse is produced. A late mem_rdata_valid is ignored.
  - Back-to-back: IDLE is re-entered for at least one cycle between transactions.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A 32-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When count reaches TIMEOUT_CYCLES without mem_rdata_valid: the owner's x_rdata = 32'hFFFF_FFFF, go to RESP (normal pulse), and set arb_timeout=1 until rst.
- ARB_TIMEOUT_EN undefined: no counter; WAIT lasts indefinitely; arb_timeout tied 0.

Test Plan:
- Instruction read at 0x0000_0100; downstream ready immediately, rdata 0x0000_0013 after 2 cycles → i_rdata_valid pulses once with i_rdata=0x0000_0013; mem_addr stays 0x100 throughout WAIT; d_rdata_valid stays 0.
- Both start in the first IDLE after reset (i_addr=0x200, d read 0x8000_0000) → instruction granted first, data second; mem_addr sequence 0x200 then 0x8000_0000; each requester gets exactly one pulse.
- Data write 0xCAFE_BABE to 0x1000_0004 with mem_cmd_ready low for 3 cycles → mem_cmd_start held 4 cycles, mem_wdata stable; return to IDLE the cycle after acceptance; no rdata_valid.
- Both requesters hold start continuously for 6 transactions → grants strictly alternate I, D, I, D, I, D.
- rst asserted for 1 cycle in WAIT, mem_rdata_valid arrives 2 cycles later → no rdata_valid pulse; all ready outputs 0 during rst; IDLE afterwards.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no mem_rdata_valid → owner's rdata_valid pulses 9-10 cycles after downstream accept with rdata=0xFFFF_FFFF; arb_timeout=1 until rst.
